// File: rtl/axis_bus_cmd_arbiter_pkg.sv
// Purpose: shared constants and types for the AXIS bus-command arbiter slice.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
// Contents: packet type bytes (A1..A4), requester-ID width, FSM state encodings,
//           round-robin pick helper.

package axis_bus_cmd_arbiter_pkg;

    // Leading type byte of each packet kind carried over the bridge.
    localparam logic [7:0] PKT_A1_RD_REQ = 8'hA1;
    localparam logic [7:0] PKT_A2_WR_REQ = 8'hA2;
    localparam logic [7:0] PKT_A3_RD_RSP = 8'hA3;
    localparam logic [7:0] PKT_A4_WR_RSP = 8'hA4;

    // Two requesters: 0 = host link, 1 = internal engine.
    localparam int REQ_ID_W = 1;
    typedef logic [REQ_ID_W-1:0] req_id_t;

    typedef enum logic {
        REQ_IDLE  = 1'b0,
        REQ_GRANT = 1'b1
    } req_state_t;

    typedef enum logic [1:0] {
        RSP_IDLE  = 2'd0,
        RSP_ROUTE = 2'd1,
        RSP_DROP  = 2'd2
    } rsp_state_t;

    // Both requesting: the one that did not win last time goes next.
    function automatic req_id_t rr_pick(input logic v0, input logic v1, input req_id_t last);
        req_id_t pick;
        if (v0 && v1) begin
            pick = ~last;
        end else if (v1) begin
            pick = 1'b1;
        end else begin
            pick = 1'b0;
        end
        return pick;
    endfunction

endpackage

// File: rtl/axis_arb_tag_fifo.sv
// Purpose: small synchronous FIFO holding the requester ID of each forwarded request packet.
// Latency: push visible at o_head the cycle after push (when it lands in an empty FIFO).
// Backpressure: o_full/o_empty reported; push while full and pop while empty are ignored.
// Ports: i_clk, i_reset (sync, active-high), i_push/i_push_dat, i_pop, o_head, o_full, o_empty.

module axis_arb_tag_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 1
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_push,
    input  logic [W-1:0] i_push_dat,
    input  logic         i_pop,
    output logic [W-1:0] o_head,
    output logic         o_full,
    output logic         o_empty
);

    localparam int PTR_W = $clog2(DEPTH);

    // One extra pointer bit separates full from empty when the indices match.
    logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
    logic [W-1:0]   mem_q [DEPTH];
    logic           push_ok;
    logic           pop_ok;

    assign o_empty = (wr_ptr_q == rd_ptr_q);
    assign o_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign o_head  = mem_q[rd_ptr_q[PTR_W-1:0]];

    assign push_ok = i_push && !o_full;
    assign pop_ok  = i_pop && !o_empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (push_ok) begin
                mem_q[wr_ptr_q[PTR_W-1:0]] <= i_push_dat;
            end
        end
    end

endmodule

// File: rtl/axis_bus_cmd_arbiter.sv
// Purpose: shares one AXIS->Wishbone bridge between two packet requesters and routes the
//          in-order response packets back to whichever requester issued each request.
// Latency: 1 cycle grant-to-first-beat, then combinational pass-through; 1 idle cycle per packet
//          on both the request and the response side.
// Backpressure: m_axis_tready passes straight to the granted requester; mK_rsp_tready passes
//          straight to r_axis_tready; no new grant while the outstanding-ID FIFO is full.
// Ports: i_clk, i_reset (sync, active-high); s0/s1_axis_* request inputs; m_axis_* to bridge;
//        r_axis_* from bridge; m0/m1_rsp_* responses out; o_orphan pulse; o_busy.
// Optional: define CMD_ARB_STATS_EN for o_pkt_cnt0/o_pkt_cnt1 (16b) and o_orphan_cnt (8b),
//           all saturating and cleared by i_reset.

module axis_bus_cmd_arbiter
    import axis_bus_cmd_arbiter_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int TAG_DEPTH = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [DATA_W-1:0] s0_axis_tdata,
    input  logic              s0_axis_tvalid,
    input  logic              s0_axis_tlast,
    output logic              s0_axis_tready,
    input  logic [DATA_W-1:0] s1_axis_tdata,
    input  logic              s1_axis_tvalid,
    input  logic              s1_axis_tlast,
    output logic              s1_axis_tready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    output logic              m_axis_tlast,
    input  logic              m_axis_tready,
    input  logic [DATA_W-1:0] r_axis_tdata,
    input  logic              r_axis_tvalid,
    input  logic              r_axis_tlast,
    output logic              r_axis_tready,
    output logic [DATA_W-1:0] m0_rsp_tdata,
    output logic              m0_rsp_tvalid,
    output logic              m0_rsp_tlast,
    input  logic              m0_rsp_tready,
    output logic [DATA_W-1:0] m1_rsp_tdata,
    output logic              m1_rsp_tvalid,
    output logic              m1_rsp_tlast,
    input  logic              m1_rsp_tready,
    output logic              o_orphan,
    output logic              o_busy
`ifdef CMD_ARB_STATS_EN
    ,
    output logic [15:0]       o_pkt_cnt0,
    output logic [15:0]       o_pkt_cnt1,
    output logic [7:0]        o_orphan_cnt
`endif
);

    req_state_t req_state_q, req_state_d;
    req_id_t    grant_q, grant_d;
    req_id_t    rr_last_q, rr_last_d;
    rsp_state_t rsp_state_q, rsp_state_d;
    req_id_t    route_q, route_d;
    logic       orphan_q, orphan_d;
    logic       busy_q;
    logic       req_done;

    logic       tag_push;
    logic       tag_pop;
    req_id_t    tag_head;
    logic       tag_full;
    logic       tag_empty;

    axis_arb_tag_fifo #(
        .DEPTH (TAG_DEPTH),
        .W     (REQ_ID_W)
    ) u_tag_fifo (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_push     (tag_push),
        .i_push_dat (grant_d),
        .i_pop      (tag_pop),
        .o_head     (tag_head),
        .o_full     (tag_full),
        .o_empty    (tag_empty)
    );

    // Request side: one whole packet per grant, no preemption once granted.
    always_comb begin
        req_state_d    = req_state_q;
        grant_d        = grant_q;
        rr_last_d      = rr_last_q;
        tag_push       = 1'b0;
        req_done       = 1'b0;
        m_axis_tdata   = '0;
        m_axis_tvalid  = 1'b0;
        m_axis_tlast   = 1'b0;
        s0_axis_tready = 1'b0;
        s1_axis_tready = 1'b0;
        case (req_state_q)
            REQ_IDLE: begin
                // The ID is queued at grant time so a fast bridge response always finds it.
                if (!tag_full && (s0_axis_tvalid || s1_axis_tvalid)) begin
                    grant_d     = rr_pick(s0_axis_tvalid, s1_axis_tvalid, rr_last_q);
                    rr_last_d   = grant_d;
                    tag_push    = 1'b1;
                    req_state_d = REQ_GRANT;
                end
            end
            REQ_GRANT: begin
                if (grant_q == 1'b0) begin
                    m_axis_tdata   = s0_axis_tdata;
                    m_axis_tvalid  = s0_axis_tvalid;
                    m_axis_tlast   = s0_axis_tlast;
                    s0_axis_tready = m_axis_tready;
                end else begin
                    m_axis_tdata   = s1_axis_tdata;
                    m_axis_tvalid  = s1_axis_tvalid;
                    m_axis_tlast   = s1_axis_tlast;
                    s1_axis_tready = m_axis_tready;
                end
                if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
                    req_done    = 1'b1;
                    req_state_d = REQ_IDLE;
                end
            end
            default: req_state_d = REQ_IDLE;
        endcase
    end

    // Response side: responses come back in request order, so the FIFO head names the owner.
    always_comb begin
        rsp_state_d   = rsp_state_q;
        route_d       = route_q;
        orphan_d      = 1'b0;
        tag_pop       = 1'b0;
        r_axis_tready = 1'b0;
        m0_rsp_tdata  = '0;
        m0_rsp_tvalid = 1'b0;
        m0_rsp_tlast  = 1'b0;
        m1_rsp_tdata  = '0;
        m1_rsp_tvalid = 1'b0;
        m1_rsp_tlast  = 1'b0;
        case (rsp_state_q)
            RSP_IDLE: begin
                if (r_axis_tvalid) begin
                    if (!tag_empty) begin
                        route_d     = tag_head;
                        rsp_state_d = RSP_ROUTE;
                    end else begin
                        orphan_d    = 1'b1;
                        rsp_state_d = RSP_DROP;
                    end
                end
            end
            RSP_ROUTE: begin
                if (route_q == 1'b0) begin
                    m0_rsp_tdata  = r_axis_tdata;
                    m0_rsp_tvalid = r_axis_tvalid;
                    m0_rsp_tlast  = r_axis_tlast;
                    r_axis_tready = m0_rsp_tready;
                end else begin
                    m1_rsp_tdata  = r_axis_tdata;
                    m1_rsp_tvalid = r_axis_tvalid;
                    m1_rsp_tlast  = r_axis_tlast;
                    r_axis_tready = m1_rsp_tready;
                end
                if (r_axis_tvalid && r_axis_tready && r_axis_tlast) begin
                    tag_pop     = 1'b1;
                    rsp_state_d = RSP_IDLE;
                end
            end
            RSP_DROP: begin
                // Nobody owns this packet: sink it so the bridge does not wedge.
                r_axis_tready = 1'b1;
                if (r_axis_tvalid && r_axis_tlast) begin
                    rsp_state_d = RSP_IDLE;
                end
            end
            default: rsp_state_d = RSP_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            req_state_q <= REQ_IDLE;
            grant_q     <= 1'b0;
            rr_last_q   <= 1'b1;
            rsp_state_q <= RSP_IDLE;
            route_q     <= 1'b0;
            orphan_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            req_state_q <= req_state_d;
            grant_q     <= grant_d;
            rr_last_q   <= rr_last_d;
            rsp_state_q <= rsp_state_d;
            route_q     <= route_d;
            orphan_q    <= orphan_d;
            busy_q      <= (req_state_q != REQ_IDLE) || !tag_empty;
        end
    end

    assign o_orphan = orphan_q;
    assign o_busy   = busy_q;

`ifdef CMD_ARB_STATS_EN
    logic [15:0] pkt_cnt0_q;
    logic [15:0] pkt_cnt1_q;
    logic [7:0]  orphan_cnt_q;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            pkt_cnt0_q   <= '0;
            pkt_cnt1_q   <= '0;
            orphan_cnt_q <= '0;
        end else begin
            if (req_done && (grant_q == 1'b0) && (pkt_cnt0_q != 16'hFFFF)) begin
                pkt_cnt0_q <= pkt_cnt0_q + 16'd1;
            end
            if (req_done && (grant_q == 1'b1) && (pkt_cnt1_q != 16'hFFFF)) begin
                pkt_cnt1_q <= pkt_cnt1_q + 16'd1;
            end
            if (orphan_d && (orphan_cnt_q != 8'hFF)) begin
                orphan_cnt_q <= orphan_cnt_q + 8'd1;
            end
        end
    end

    assign o_pkt_cnt0   = pkt_cnt0_q;
    assign o_pkt_cnt1   = pkt_cnt1_q;
    assign o_orphan_cnt = orphan_cnt_q;
`endif

endmodule

// File: tb/tb_axis_bus_cmd_arbiter.sv
// Purpose: self-checking bench for axis_bus_cmd_arbiter (table of single-packet transactions
//          plus hand-written sequences for arbitration, FIFO-full, orphan and reset cases).
// Latency/backpressure: inputs driven #1 after the rising edge, outputs sampled on the falling edge.

module tb_axis_bus_cmd_arbiter;
    import axis_bus_cmd_arbiter_pkg::*;

    typedef logic [7:0] bytes_t [$];

    typedef struct {
        int         id;
        logic [7:0] op;
        int         nreq;
        logic [7:0] rop;
        int         nrsp;
        int         exp_route;
        int         exp_beats;
    } vec_t;

    logic       i_clk = 1'b0;
    logic       i_reset;
    logic [7:0] s0_axis_tdata, s1_axis_tdata, m_axis_tdata, r_axis_tdata;
    logic       s0_axis_tvalid, s0_axis_tlast, s0_axis_tready;
    logic       s1_axis_tvalid, s1_axis_tlast, s1_axis_tready;
    logic       m_axis_tvalid, m_axis_tlast, m_axis_tready;
    logic       r_axis_tvalid, r_axis_tlast, r_axis_tready;
    logic [7:0] m0_rsp_tdata, m1_rsp_tdata;
    logic       m0_rsp_tvalid, m0_rsp_tlast, m0_rsp_tready;
    logic       m1_rsp_tvalid, m1_rsp_tlast, m1_rsp_tready;
    logic       o_orphan, o_busy;
`ifdef CMD_ARB_STATS_EN
    logic [15:0] o_pkt_cnt0, o_pkt_cnt1;
    logic [7:0]  o_orphan_cnt;
`endif

    always #5 i_clk = ~i_clk;

    axis_bus_cmd_arbiter #(.DATA_W(8), .TAG_DEPTH(4)) dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .s0_axis_tdata  (s0_axis_tdata),
        .s0_axis_tvalid (s0_axis_tvalid),
        .s0_axis_tlast  (s0_axis_tlast),
        .s0_axis_tready (s0_axis_tready),
        .s1_axis_tdata  (s1_axis_tdata),
        .s1_axis_tvalid (s1_axis_tvalid),
        .s1_axis_tlast  (s1_axis_tlast),
        .s1_axis_tready (s1_axis_tready),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tlast   (m_axis_tlast),
        .m_axis_tready  (m_axis_tready),
        .r_axis_tdata   (r_axis_tdata),
        .r_axis_tvalid  (r_axis_tvalid),
        .r_axis_tlast   (r_axis_tlast),
        .r_axis_tready  (r_axis_tready),
        .m0_rsp_tdata   (m0_rsp_tdata),
        .m0_rsp_tvalid  (m0_rsp_tvalid),
        .m0_rsp_tlast   (m0_rsp_tlast),
        .m0_rsp_tready  (m0_rsp_tready),
        .m1_rsp_tdata   (m1_rsp_tdata),
        .m1_rsp_tvalid  (m1_rsp_tvalid),
        .m1_rsp_tlast   (m1_rsp_tlast),
        .m1_rsp_tready  (m1_rsp_tready),
        .o_orphan       (o_orphan),
        .o_busy         (o_busy)
`ifdef CMD_ARB_STATS_EN
        ,
        .o_pkt_cnt0     (o_pkt_cnt0),
        .o_pkt_cnt1     (o_pkt_cnt1),
        .o_orphan_cnt   (o_orphan_cnt)
`endif
    );

    int         n_checks = 0;
    int         n_errors = 0;
    logic [8:0] exp_req0 [$];
    logic [8:0] exp_req1 [$];
    logic [8:0] exp_rsp0 [$];
    logic [8:0] exp_rsp1 [$];
    int         grant_log [$];
    int         fwd_beats = 0;
    int         rsp_hs0 = 0;
    int         rsp_hs1 = 0;
    int         r_hs = 0;
    int         orphan_cycles = 0;
    bit         in_pkt = 1'b0;
    bit         throttle = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: event did not occur (expected it to)", name);
    endtask

    function automatic bytes_t mk_req(input logic [7:0] op, input int n, input int seed);
        bytes_t b;
        b.push_back(op);
        for (int i = 1; i < n; i++) begin
            if (op == PKT_A1_RD_REQ) b.push_back((i == n - 1) ? 8'h04 : 8'h00);
            else                     b.push_back(8'(seed * 16 + i));
        end
        return b;
    endfunction

    function automatic bytes_t mk_rsp(input logic [7:0] op, input int n);
        bytes_t b;
        b.push_back(op);
        for (int i = 1; i < n; i++) b.push_back(8'($urandom_range(0, 255)));
        return b;
    endfunction

    task automatic set_s(input int id, input logic v, input logic [7:0] d, input logic l);
        if (id == 0) begin
            s0_axis_tvalid = v; s0_axis_tdata = d; s0_axis_tlast = l;
        end else begin
            s1_axis_tvalid = v; s1_axis_tdata = d; s1_axis_tlast = l;
        end
    endtask

    function automatic logic s_rdy(input int id);
        return (id == 0) ? s0_axis_tready : s1_axis_tready;
    endfunction

    // Returns #1 after the edge on which the presented beat was accepted.
    task automatic wait_hs_s(input int id);
        int t = 0;
        @(negedge i_clk);
        while (!s_rdy(id) && t < 400) begin
            @(negedge i_clk);
            t++;
        end
        if (t >= 400) fail_now("req_handshake_timeout");
        @(posedge i_clk);
        #1;
    endtask

    task automatic send_req(input int id, input bytes_t b);
        for (int i = 0; i < b.size(); i++) begin
            logic l;
            l = (i == b.size() - 1);
            if (id == 0) exp_req0.push_back({l, b[i]});
            else         exp_req1.push_back({l, b[i]});
            set_s(id, 1'b1, b[i], l);
            wait_hs_s(id);
        end
        set_s(id, 1'b0, 8'h00, 1'b0);
    endtask

    // route 0/1 = expected owner, 2 = expected to be dropped as an orphan.
    task automatic send_rsp(input bytes_t b, input int route);
        for (int i = 0; i < b.size(); i++) begin
            int   t = 0;
            logic l;
            l = (i == b.size() - 1);
            if (route == 0) exp_rsp0.push_back({l, b[i]});
            if (route == 1) exp_rsp1.push_back({l, b[i]});
            r_axis_tvalid = 1'b1; r_axis_tdata = b[i]; r_axis_tlast = l;
            @(negedge i_clk);
            while (!r_axis_tready && t < 400) begin
                @(negedge i_clk);
                t++;
            end
            if (t >= 400) fail_now("rsp_handshake_timeout");
            @(posedge i_clk);
            #1;
        end
        r_axis_tvalid = 1'b0; r_axis_tdata = 8'h00; r_axis_tlast = 1'b0;
    endtask

    task automatic idle_inputs();
        set_s(0, 1'b0, 8'h00, 1'b0);
        set_s(1, 1'b0, 8'h00, 1'b0);
        r_axis_tvalid = 1'b0; r_axis_tdata = 8'h00; r_axis_tlast = 1'b0;
        m_axis_tready = 1'b1; m0_rsp_tready = 1'b1; m1_rsp_tready = 1'b1;
    endtask

    task automatic clear_sb();
        exp_req0.delete(); exp_req1.delete(); exp_rsp0.delete(); exp_rsp1.delete();
        grant_log.delete();
    endtask

    task automatic do_reset();
        @(posedge i_clk);
        #1;
        throttle = 1'b0;
        i_reset  = 1'b1;
        idle_inputs();
        repeat (2) @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        clear_sb();
    endtask

    task automatic check_drained(input string name);
        repeat (3) @(posedge i_clk);
        #1;
        check({name, "_busy_idle"}, 32'(o_busy), 32'd0);
        check({name, "_sb_empty"}, 32'(exp_req0.size() + exp_req1.size() + exp_rsp0.size() + exp_rsp1.size()), 32'd0);
    endtask

    // Monitors: scoreboard pops on every handshake seen at the DUT outputs.
    initial begin
        int         src;
        logic [8:0] e;
        forever begin
            @(negedge i_clk);
            if (i_reset) begin
                in_pkt = 1'b0;
            end else begin
                if (m_axis_tvalid && m_axis_tready) begin
                    check("req_one_src_ready", 32'(s0_axis_tready ^ s1_axis_tready), 32'd1);
                    src = s1_axis_tready ? 1 : 0;
                    if (src == 0 && exp_req0.size() == 0) fail_now("req0_beat_expected");
                    else if (src == 1 && exp_req1.size() == 0) fail_now("req1_beat_expected");
                    else begin
                        e = (src == 0) ? exp_req0.pop_front() : exp_req1.pop_front();
                        check(src == 0 ? "req0_beat" : "req1_beat", 32'({m_axis_tlast, m_axis_tdata}), 32'(e));
                    end
                    if (!in_pkt) grant_log.push_back(src);
                    in_pkt = !m_axis_tlast;
                    fwd_beats++;
                end
                if (m0_rsp_tvalid && m0_rsp_tready) begin
                    rsp_hs0++;
                    if (exp_rsp0.size() == 0) fail_now("rsp0_beat_expected");
                    else check("rsp0_beat", 32'({m0_rsp_tlast, m0_rsp_tdata}), 32'(exp_rsp0.pop_front()));
                end
                if (m1_rsp_tvalid && m1_rsp_tready) begin
                    rsp_hs1++;
                    if (exp_rsp1.size() == 0) fail_now("rsp1_beat_expected");
                    else check("rsp1_beat", 32'({m1_rsp_tlast, m1_rsp_tdata}), 32'(exp_rsp1.pop_front()));
                end
                if (r_axis_tvalid && r_axis_tready) r_hs++;
                if (o_orphan) orphan_cycles++;
            end
        end
    end

    // Random ready throttling on all downstream ports when enabled.
    initial begin
        forever begin
            @(posedge i_clk);
            #1;
            if (throttle) begin
                m_axis_tready = 1'($urandom_range(0, 1));
                m0_rsp_tready = 1'($urandom_range(0, 1));
                m1_rsp_tready = 1'($urandom_range(0, 1));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [4];
        int   fb, gl, h0, h1, oc, rh;
        bit   stall_ok;

        vecs[0] = '{id: 0, op: PKT_A1_RD_REQ, nreq: 7, rop: PKT_A3_RD_RSP, nrsp: 5, exp_route: 0, exp_beats: 7};
        vecs[1] = '{id: 1, op: PKT_A1_RD_REQ, nreq: 7, rop: PKT_A3_RD_RSP, nrsp: 5, exp_route: 1, exp_beats: 7};
        vecs[2] = '{id: 0, op: PKT_A2_WR_REQ, nreq: 9, rop: PKT_A4_WR_RSP, nrsp: 1, exp_route: 0, exp_beats: 9};
        vecs[3] = '{id: 1, op: PKT_A2_WR_REQ, nreq: 9, rop: PKT_A4_WR_RSP, nrsp: 2, exp_route: 1, exp_beats: 9};

        // Reset state.
        i_reset = 1'b1;
        idle_inputs();
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        check("rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("rst_m_tdata", 32'(m_axis_tdata), 32'd0);
        check("rst_s0_tready", 32'(s0_axis_tready), 32'd0);
        check("rst_s1_tready", 32'(s1_axis_tready), 32'd0);
        check("rst_r_tready", 32'(r_axis_tready), 32'd0);
        check("rst_m0_tvalid", 32'(m0_rsp_tvalid), 32'd0);
        check("rst_m1_tvalid", 32'(m1_rsp_tvalid), 32'd0);
        check("rst_orphan", 32'(o_orphan), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        @(posedge i_clk);
        #1;
        i_reset = 1'b0;

        // Table: one request, one response, each on its own.
        for (int v = 0; v < 4; v++) begin
            fb = fwd_beats; gl = grant_log.size(); h0 = rsp_hs0; h1 = rsp_hs1;
            send_req(vecs[v].id, mk_req(vecs[v].op, vecs[v].nreq, v));
            check("vec_fwd_beats", 32'(fwd_beats - fb), 32'(vecs[v].exp_beats));
            if (grant_log.size() > gl) check("vec_grant_src", 32'(grant_log[gl]), 32'(vecs[v].exp_route));
            else fail_now("vec_grant_logged");
            send_rsp(mk_rsp(vecs[v].rop, vecs[v].nrsp), vecs[v].exp_route);
            check("vec_rsp0_beats", 32'(rsp_hs0 - h0), 32'(vecs[v].exp_route == 0 ? vecs[v].nrsp : 0));
            check("vec_rsp1_beats", 32'(rsp_hs1 - h1), 32'(vecs[v].exp_route == 1 ? vecs[v].nrsp : 0));
            check_drained("vec");
        end

        // Both requesters valid in the same cycle right after reset: 0 first, then 1.
        do_reset();
        fork
            send_req(0, mk_req(PKT_A1_RD_REQ, 7, 0));
            send_req(1, mk_req(PKT_A2_WR_REQ, 9, 5));
        join
        check("tie_grant_cnt", 32'(grant_log.size()), 32'd2);
        if (grant_log.size() >= 2) begin
            check("tie_first", 32'(grant_log[0]), 32'd0);
            check("tie_second", 32'(grant_log[1]), 32'd1);
        end
        h0 = rsp_hs0; h1 = rsp_hs1;
        send_rsp(mk_rsp(PKT_A3_RD_RSP, 5), 0);
        send_rsp(mk_rsp(PKT_A4_WR_RSP, 1), 1);
        check("tie_rsp0_beats", 32'(rsp_hs0 - h0), 32'd5);
        check("tie_rsp1_beats", 32'(rsp_hs1 - h1), 32'd1);
        check_drained("tie");

        // Continuous contention with random downstream stalls: strict alternation.
        do_reset();
        throttle = 1'b1;
        fork
            for (int p = 0; p < 6; p++) send_req(0, mk_req(PKT_A1_RD_REQ, 7, p));
            for (int p = 0; p < 6; p++) send_req(1, mk_req(PKT_A2_WR_REQ, 5, p + 8));
            for (int i = 0; i < 12; i++) begin
                int t = 0;
                while (grant_log.size() <= i && t < 2000) begin
                    @(posedge i_clk);
                    #1;
                    t++;
                end
                if (grant_log.size() <= i) fail_now("rr_grant_wait");
                else send_rsp(mk_rsp((grant_log[i] == 0) ? PKT_A3_RD_RSP : PKT_A4_WR_RSP, 3), grant_log[i]);
            end
        join
        throttle = 1'b0;
        idle_inputs();
        check("rr_grant_cnt", 32'(grant_log.size()), 32'd12);
        for (int i = 0; i < 12 && i < grant_log.size(); i++) begin
            check("rr_order", 32'(grant_log[i]), 32'(i % 2));
        end
        check_drained("rr");

        // Four outstanding requests fill the tag FIFO; the fifth waits for the first response.
        do_reset();
        send_req(0, mk_req(PKT_A1_RD_REQ, 7, 0));
        send_req(1, mk_req(PKT_A1_RD_REQ, 7, 1));
        send_req(0, mk_req(PKT_A2_WR_REQ, 4, 2));
        send_req(1, mk_req(PKT_A2_WR_REQ, 4, 3));
        @(negedge i_clk);
        check("full_busy", 32'(o_busy), 32'd1);
        @(posedge i_clk);
        #1;
        fork
            send_req(0, mk_req(PKT_A1_RD_REQ, 7, 4));
            begin
                stall_ok = 1'b1;
                repeat (8) begin
                    @(negedge i_clk);
                    if (s0_axis_tready || m_axis_tvalid) stall_ok = 1'b0;
                end
                check("full_no_grant", 32'(stall_ok), 32'd1);
                check("full_grant_cnt", 32'(grant_log.size()), 32'd4);
                @(posedge i_clk);
                #1;
                send_rsp(mk_rsp(PKT_A3_RD_RSP, 5), 0);
            end
        join
        check("full_fifth_granted", 32'(grant_log.size()), 32'd5);
        if (grant_log.size() == 5) check("full_fifth_src", 32'(grant_log[4]), 32'd0);
        send_rsp(mk_rsp(PKT_A3_RD_RSP, 5), 1);
        send_rsp(mk_rsp(PKT_A4_WR_RSP, 1), 0);
        send_rsp(mk_rsp(PKT_A4_WR_RSP, 1), 1);
        send_rsp(mk_rsp(PKT_A3_RD_RSP, 5), 0);
        check_drained("full");

        // Response with nothing outstanding: one orphan pulse, packet sunk, nothing forwarded.
        do_reset();
        oc = orphan_cycles; h0 = rsp_hs0; h1 = rsp_hs1; rh = r_hs;
        send_rsp(mk_rsp(PKT_A3_RD_RSP, 5), 2);
        repeat (2) @(posedge i_clk);
        #1;
        check("orphan_pulse_cycles", 32'(orphan_cycles - oc), 32'd1);
        check("orphan_beats_sunk", 32'(r_hs - rh), 32'd5);
        check("orphan_no_rsp0", 32'(rsp_hs0 - h0), 32'd0);
        check("orphan_no_rsp1", 32'(rsp_hs1 - h1), 32'd0);

        // Reset in the middle of a packet (beat 3 of 7), then a clean packet.
        do_reset();
        begin
            bytes_t p;
            p = mk_req(PKT_A1_RD_REQ, 7, 0);
            for (int i = 0; i < 3; i++) begin
                exp_req0.push_back({1'b0, p[i]});
                set_s(0, 1'b1, p[i], 1'b0);
                wait_hs_s(0);
            end
            set_s(0, 1'b1, p[3], 1'b0);
            i_reset = 1'b1;
            @(posedge i_clk);
            #1;
            i_reset = 1'b0;
            set_s(0, 1'b0, 8'h00, 1'b0);
            clear_sb();
            @(negedge i_clk);
            check("midrst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
            check("midrst_s0_tready", 32'(s0_axis_tready), 32'd0);
            check("midrst_s1_tready", 32'(s1_axis_tready), 32'd0);
            check("midrst_r_tready", 32'(r_axis_tready), 32'd0);
            check("midrst_rsp_tvalid", 32'({m0_rsp_tvalid, m1_rsp_tvalid}), 32'd0);
            check("midrst_busy", 32'(o_busy), 32'd0);
            @(posedge i_clk);
            #1;
        end
        fb = fwd_beats; h0 = rsp_hs0;
        send_req(0, mk_req(PKT_A1_RD_REQ, 7, 0));
        check("midrst_fwd_beats", 32'(fwd_beats - fb), 32'd7);
        send_rsp(mk_rsp(PKT_A3_RD_RSP, 5), 0);
        check("midrst_rsp0_beats", 32'(rsp_hs0 - h0), 32'd5);
        // The abandoned packet's tag must be gone: the next response is an orphan.
        oc = orphan_cycles;
        send_rsp(mk_rsp(PKT_A3_RD_RSP, 2), 2);
        repeat (2) @(posedge i_clk);
        #1;
        check("midrst_stale_tag_gone", 32'(orphan_cycles - oc), 32'd1);
        check_drained("midrst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
